// File: rtl/biu_pkg.sv
// biu_pkg: shared state encoding and S1/S0 status codes for the multiplexed bus controller
package biu_pkg;
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, THOLD} biu_state_t;
  localparam logic [1:0] S_FETCH = 2'b11;
  localparam logic [1:0] S_READ  = 2'b10;
  localparam logic [1:0] S_WRITE = 2'b01;
  localparam logic [1:0] S_IDLE  = 2'b00;
  // a write wins over the fetch flag, so a fetch+write request reports as a write
  function automatic logic [1:0] status_of(input logic write, input logic fetch);
    return write ? S_WRITE : fetch ? S_FETCH : S_READ;
  endfunction
endpackage

// File: rtl/mux_bus_controller_if.sv
// mux_bus_controller_if: core request/response plus external pad signals of the bus controller
interface mux_bus_controller_if #(parameter int AW = 16, parameter int DW = 8);
  logic req_valid, req_ready, req_write, req_io, req_fetch;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic ready, hold, hlda, bus_float;
  logic [AW-DW-1:0] haddress;
  logic [DW-1:0] ad_out, ad_in;
  logic ad_oe, ale, rdn, wrn, iomn, s1, s0;
  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_io, req_fetch, ready, hold, ad_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, hlda, bus_float, haddress,
           ad_out, ad_oe, ale, rdn, wrn, iomn, s1, s0
  );
  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_io, req_fetch, ready, hold, ad_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, hlda, bus_float, haddress,
           ad_out, ad_oe, ale, rdn, wrn, iomn, s1, s0
  );
endinterface

// File: rtl/biu_wait_ctr.sv
// biu_wait_ctr: counts TW cycles after T2; forced waits first, then READY waits up to the timeout
module biu_wait_ctr #(
  parameter int WAIT_STATES = 0,
  parameter int MAX_WAIT    = 0
) (
  input  logic clk,
  input  logic resetn_in,
  input  logic load,
  input  logic active,
  input  logic ready,
  output logic done,
  output logic timeout
);
  localparam int LIM = WAIT_STATES + MAX_WAIT;
  localparam int CW  = $clog2(LIM + 2);
  logic [CW-1:0] cnt;
  logic forced;
  always_comb begin
    forced  = int'(cnt) < WAIT_STATES;
    timeout = MAX_WAIT != 0 && !forced && int'(cnt) == LIM;
    done    = !forced && (ready || timeout);
  end
  // saturates at LIM, which is also where an unbounded wait parks
  always_ff @(posedge clk)
    if (!resetn_in || load) cnt <= '0;
    else if (active && !done && int'(cnt) != LIM) cnt <= cnt + CW'(1);
endmodule

// File: rtl/mux_bus_controller.sv
// mux_bus_controller: turns single-beat core requests into T1/T2/[TW]/T3 machine cycles with HOLD/HLDA
module mux_bus_controller
  import biu_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0,
  parameter int MAX_WAIT    = 0
) (
  input logic clk,
  input logic resetn_in,
  mux_bus_controller_if.master bus
);
  biu_state_t state;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic write, io, fetch, err;
  logic accept, in_wait, done, timeout, busy, strobe;
  assign accept  = bus.req_valid && bus.req_ready;
  assign in_wait = state == T2 || state == TW;
  biu_wait_ctr #(.WAIT_STATES(WAIT_STATES), .MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(clk), .resetn_in(resetn_in), .load(state == T1), .active(in_wait),
    .ready(bus.ready), .done(done), .timeout(timeout)
  );
  always_ff @(posedge clk) begin
    if (!resetn_in) begin
      state         <= IDLE;
      addr          <= '0;
      wdata         <= '0;
      write         <= 1'b0;
      io            <= 1'b0;
      fetch         <= 1'b0;
      err           <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= state == T3;
      if (state == T3) begin
        bus.rsp_rdata <= write ? '0 : bus.ad_in;
        bus.rsp_err   <= err;
      end
      if (accept) begin
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        write <= bus.req_write;
        io    <= bus.req_io;
        fetch <= bus.req_fetch;
        err   <= 1'b0;
      end
      case (state)
        IDLE, T3: state <= bus.hold ? THOLD : accept ? T1 : IDLE;
        T1:       state <= T2;
        T2, TW: begin
          state <= done ? T3 : TW;
          if (done && timeout && !bus.ready) err <= 1'b1;
        end
        THOLD:    state <= bus.hold ? THOLD : IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
  // pins are a pure decode of state and the latched request
  always_comb begin
    busy          = state inside {T1, T2, TW, T3};
    strobe        = state inside {T2, TW, T3};
    bus.req_ready = (state == IDLE || state == T3) && !bus.hold;
    bus.ale       = state == T1;
    bus.rdn       = !(strobe && !write);
    bus.wrn       = !(strobe && write);
    bus.ad_oe     = state == T1 || (strobe && write);
    bus.ad_out    = state == T1 ? addr[DW-1:0] : wdata;
    bus.haddress  = busy ? addr[AW-1:DW] : '0;
    bus.iomn      = busy && io;
    {bus.s1, bus.s0} = busy ? status_of(write, fetch) : S_IDLE;
    bus.hlda      = state == THOLD;
    bus.bus_float = state == THOLD;
  end
endmodule

// File: tb/tb_mux_bus_controller.sv
// tb_mux_bus_controller: three wait-state variants driven in lockstep and checked against a timeline model
module tb_mux_bus_controller;
  typedef struct packed {
    logic req_ready; logic rsp_valid; logic [7:0] rsp_rdata; logic rsp_err; logic hlda; logic bus_float;
    logic [7:0] haddress; logic [7:0] ad_out; logic ad_oe; logic ale; logic rdn; logic wrn; logic iomn; logic [1:0] s;
  } pins_t;
  typedef struct {
    logic wr; logic io; logic fe; logic [15:0] a; logic [7:0] wd; int kabs; logic [7:0] ad;
    logic [2:0][7:0] low; logic [2:0] err; logic [7:0] rd;
  } vec_t;

  logic clk = 1'b0, resetn_in = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_write = 0, req_io = 0, req_fetch = 0, ready = 1, hold = 0;
  logic [15:0] req_addr = '0;
  logic [7:0] req_wdata = '0, ad_in = '0;
  logic [37:0] stim;
  assign stim = {req_valid, req_write, req_io, req_fetch, req_addr, req_wdata, ready, hold, ad_in};

  mux_bus_controller_if #(.AW(16), .DW(8)) b0(), b1(), b2();
  assign {b0.req_valid, b0.req_write, b0.req_io, b0.req_fetch, b0.req_addr, b0.req_wdata, b0.ready, b0.hold, b0.ad_in} = stim;
  assign {b1.req_valid, b1.req_write, b1.req_io, b1.req_fetch, b1.req_addr, b1.req_wdata, b1.ready, b1.hold, b1.ad_in} = stim;
  assign {b2.req_valid, b2.req_write, b2.req_io, b2.req_fetch, b2.req_addr, b2.req_wdata, b2.ready, b2.hold, b2.ad_in} = stim;
  mux_bus_controller #(.WAIT_STATES(0), .MAX_WAIT(0)) u0 (.clk(clk), .resetn_in(resetn_in), .bus(b0));
  mux_bus_controller #(.WAIT_STATES(2), .MAX_WAIT(0)) u1 (.clk(clk), .resetn_in(resetn_in), .bus(b1));
  mux_bus_controller #(.WAIT_STATES(0), .MAX_WAIT(4)) u2 (.clk(clk), .resetn_in(resetn_in), .bus(b2));

  pins_t obs [3];
  assign obs[0] = {b0.req_ready, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err, b0.hlda, b0.bus_float, b0.haddress, b0.ad_out, b0.ad_oe, b0.ale, b0.rdn, b0.wrn, b0.iomn, b0.s1, b0.s0};
  assign obs[1] = {b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err, b1.hlda, b1.bus_float, b1.haddress, b1.ad_out, b1.ad_oe, b1.ale, b1.rdn, b1.wrn, b1.iomn, b1.s1, b1.s0};
  assign obs[2] = {b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_err, b2.hlda, b2.bus_float, b2.haddress, b2.ad_out, b2.ad_oe, b2.ale, b2.rdn, b2.wrn, b2.iomn, b2.s1, b2.s0};

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input pins_t got, input pins_t exp, input pins_t msk);
    n_cmp++;
    if ((got & msk) != (exp & msk)) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (mask %h)", nm, got, exp, msk);
    end
  endtask

  task automatic check_v(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // variant d: u0 W=0 M=0, u1 W=2 M=0, u2 W=0 M=4
  function automatic int w_of(input int d); return d == 1 ? 2 : 0; endfunction
  function automatic int m_of(input int d); return d == 2 ? 4 : 0; endfunction
  // kabs = number of READY=0 samples counted from the end of T2, forced ones included
  function automatic int k_of(input int d, input int kabs); return kabs > w_of(d) ? kabs - w_of(d) : 0; endfunction
  function automatic logic err_of(input int d, input int kabs); return m_of(d) != 0 && k_of(d, kabs) > m_of(d); endfunction
  function automatic int t3_of(input int d, input int kabs);
    int k = k_of(d, kabs);
    return 2 + w_of(d) + ((m_of(d) != 0 && k > m_of(d)) ? m_of(d) : k);
  endfunction

  function automatic pins_t idle_pins();
    pins_t p = '0;
    p.rdn = 1'b1; p.wrn = 1'b1; p.req_ready = 1'b1;
    return p;
  endfunction

  // expected pins in cycle c after acceptance (c=0 is T1, c=t3c is T3)
  task automatic expect_at(input int c, input int t3c, input logic wr, input logic io, input logic fe,
                           input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd, input logic er,
                           output pins_t e, output pins_t m);
    e = idle_pins();
    m = '1;
    m.rsp_rdata = '0; m.rsp_err = 1'b0; m.ad_out = '0;
    if (c <= t3c) begin
      e.req_ready = c == t3c;
      e.haddress = a[15:8];
      e.iomn = io;
      e.s = wr ? 2'b01 : fe ? 2'b11 : 2'b10;
      if (c == 0) begin e.ale = 1'b1; e.ad_oe = 1'b1; e.ad_out = a[7:0]; m.ad_out = '1; end
      else if (wr) begin e.wrn = 1'b0; e.ad_oe = 1'b1; e.ad_out = wd; m.ad_out = '1; end
      else e.rdn = 1'b0;
    end else begin
      m.haddress = '0; m.iomn = 1'b0;
      if (c == t3c + 1) begin
        e.rsp_valid = 1'b1; e.rsp_rdata = rd; e.rsp_err = er;
        m.rsp_rdata = '1; m.rsp_err = 1'b1;
      end
    end
  endtask

  // one request issued to all three variants; called and returns at posedge+1
  task automatic run_txn(input logic wr, input logic io, input logic fe, input logic [15:0] a, input logic [7:0] wd,
                         input int kabs, input logic rnd, input logic [7:0] ad_fix,
                         output logic [2:0][7:0] low, output logic [2:0] errs, output logic [2:0][7:0] rds);
    int t3c [3];
    int last = 0;
    logic [7:0] adv [64];
    pins_t e, m;
    for (int d = 0; d < 3; d++) begin
      t3c[d] = t3_of(d, kabs);
      if (t3c[d] + 2 > last) last = t3c[d] + 2;
    end
    low = '0; errs = '0; rds = '0;
    req_write = wr; req_io = io; req_fetch = fe; req_addr = a; req_wdata = wd; req_valid = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c <= last; c++) begin
      ready = c == 0 || (c - 1) >= kabs;
      ad_in = rnd ? 8'($urandom) : ad_fix;
      adv[c] = ad_in;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        expect_at(c, t3c[d], wr, io, fe, a, wd, wr ? 8'h00 : adv[c > 0 ? c - 1 : 0], err_of(d, kabs), e, m);
        check($sformatf("u%0d cyc%0d", d, c), obs[d], e, m);
        if (!obs[d].rdn || !obs[d].wrn) low[d] = low[d] + 8'd1;
        if (obs[d].rsp_valid) begin errs[d] = obs[d].rsp_err; rds[d] = obs[d].rsp_rdata; end
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    logic [2:0][7:0] low, rds;
    logic [2:0] errs;
    logic [3:0] b2b [8];
    logic [6:0] hs [9];
    int n_rsp;
    // strobe-low counts are {u2,u1,u0}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 0,  8'hA5, {8'd2, 8'd4, 8'd2},   3'b000, 8'hA5};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0042, 8'h5A, 0,  8'hEE, {8'd2, 8'd4, 8'd2},   3'b000, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0100, 8'h00, 3,  8'h3C, {8'd5, 8'd5, 8'd5},   3'b000, 8'h3C};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h8001, 8'h00, 10, 8'h96, {8'd6, 8'd12, 8'd12}, 3'b100, 8'h96};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 8'hC3, 4,  8'h11, {8'd6, 8'd6, 8'd6},   3'b000, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h7F20, 8'h00, 5,  8'h42, {8'd6, 8'd7, 8'd7},   3'b100, 8'h42};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'hABCD, 8'h77, 1,  8'h00, {8'd3, 8'd4, 8'd3},   3'b000, 8'h00};
    // {ale, rdn, rsp_valid, req_ready} for back-to-back reads on the W=0 variants
    b2b = '{4'b1100, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0001, 4'b0111, 4'b0101};
    // {hlda, bus_float, ale, ad_oe, rdn, rsp_valid, req_ready} for hold raised during TW
    hs = '{7'b0011100, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
           7'b1100110, 7'b1100100, 7'b1100100, 7'b0000101};

    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("reset u%0d", d), obs[d], idle_pins(), '1);
    @(posedge clk); #1;
    resetn_in = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].wr, tbl[i].io, tbl[i].fe, tbl[i].a, tbl[i].wd, tbl[i].kabs, 1'b0, tbl[i].ad, low, errs, rds);
      check_v($sformatf("tbl%0d strobe_cycles", i), 32'(low), 32'(tbl[i].low));
      check_v($sformatf("tbl%0d rsp_err", i), 32'(errs), 32'(tbl[i].err));
      check_v($sformatf("tbl%0d rsp_rdata", i), 32'(rds), 32'({3{tbl[i].rd}}));
    end

    req_addr = 16'h2000; req_write = 1'b0; req_io = 1'b0; req_fetch = 1'b0; ad_in = 8'h5C; req_valid = 1'b1;
    @(posedge clk); #1;
    n_rsp = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) req_valid = 1'b0;
      @(negedge clk);
      check_v($sformatf("b2b u0 cyc%0d", c), {obs[0].ale, obs[0].rdn, obs[0].rsp_valid, obs[0].req_ready}, b2b[c]);
      check_v($sformatf("b2b u2 cyc%0d", c), {obs[2].ale, obs[2].rdn, obs[2].rsp_valid, obs[2].req_ready}, b2b[c]);
      if (obs[0].rsp_valid) begin n_rsp++; check_v("b2b rdata", obs[0].rsp_rdata, 8'h5C); end
      @(posedge clk); #1;
    end
    check_v("b2b rsp count", n_rsp, 2);

    req_addr = 16'h3000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      ready = !(c == 1 || c == 2);
      hold = c >= 2 && c <= 6;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        check_v($sformatf("hold u%0d cyc%0d", d, c),
                {obs[d].hlda, obs[d].bus_float, obs[d].ale, obs[d].ad_oe, obs[d].rdn, obs[d].rsp_valid, obs[d].req_ready}, hs[c]);
      @(posedge clk); #1;
    end

    hold = 1'b1; req_addr = 16'h4000; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin hold = 1'b0; req_valid = 1'b0; end
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        check_v($sformatf("hold_prio u%0d cyc%0d", d, c), {obs[d].hlda, obs[d].ale, obs[d].req_ready}, c < 2 ? 3'b100 : 3'b001);
    end
    @(posedge clk); #1;

    req_addr = 16'h5000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_v("rst_mid T2 rdn", obs[0].rdn, 1'b0);
    resetn_in = 1'b0;
    @(posedge clk); #1;
    resetn_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check($sformatf("rst_mid u%0d cyc%0d", d, c), obs[d], idle_pins(), '1);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
              $urandom_range(0, 6), 1'b1, 8'h00, low, errs, rds);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
